// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: drives a synchronous-read instruction memory and buffers
// returned instructions (tagged with their byte PC) in a small FIFO for the datapath.
module fetch_queue_unit #(
  parameter int                     PC_WIDTH = 16,
  parameter int                     IR_WIDTH = 32,
  parameter int                     IMEM_AW  = 6,
  parameter int                     DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_lock,
  output logic [IMEM_AW-1:0]        o_imem_addr,
  output logic                      o_imem_en,
  input  logic [IR_WIDTH-1:0]       i_imem_rdata,
  input  logic                      i_redirect_valid,
  input  logic [PC_WIDTH-1:0]       i_redirect_pc,
  output logic                      o_inst_valid,
  output logic [IR_WIDTH-1:0]       o_inst_data,
  output logic [PC_WIDTH-1:0]       o_inst_pc,
  input  logic                      i_inst_ready,
  output logic [$clog2(DEPTH):0]    o_q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FULL, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic [PC_WIDTH-1:0]   r_req_pc;
  logic                  r_inflight;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [IR_WIDTH-1:0]   r_data_mem [DEPTH];
  logic [PC_WIDTH-1:0]   r_pc_mem   [DEPTH];

  logic                  w_redirect;
  logic                  w_room;
  logic                  w_req;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_nonempty;
  logic [CW-1:0]         w_occupied;
  logic [PC_WIDTH-1:0]   w_redirect_aligned;

  // The in-flight request holds a reserved slot, so a late response can never overflow.
  assign w_redirect         = i_redirect_valid && i_lock && (r_state != S_BOOT);
  assign w_occupied         = r_count + CW'(r_inflight);
  assign w_room             = w_occupied < CW'(DEPTH);
  assign w_req              = i_lock && !w_redirect && (r_state == S_RUN) && w_room;
  assign w_enq              = r_inflight && !w_redirect;
  assign w_nonempty         = (r_count != '0);
  assign w_deq              = o_inst_valid && i_inst_ready && !w_redirect;
  assign w_redirect_aligned = i_redirect_pc & ~PC_WIDTH'(3);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOOT:  if (i_lock) w_state_next = S_RUN;
      S_RUN: begin
        if (w_redirect)              w_state_next = S_FLUSH;
        else if (i_lock && !w_room)  w_state_next = S_FULL;
      end
      S_FULL: begin
        if (w_redirect)              w_state_next = S_FLUSH;
        else if (i_lock && w_room)   w_state_next = S_RUN;
      end
      S_FLUSH: begin
        if (w_redirect)              w_state_next = S_FLUSH;
        else if (i_lock)             w_state_next = S_RUN;
      end
      default:                       w_state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_req;
      if (w_req) r_req_pc <= r_fetch_pc;
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_aligned;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req) r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_data_mem[r_wr_ptr] <= i_imem_rdata;
      r_pc_mem[r_wr_ptr]   <= r_req_pc;
    end
  end

  // Head fields read as zero when empty so the reset values hold without resetting storage.
  assign o_imem_en    = w_req;
  assign o_imem_addr  = r_fetch_pc[IMEM_AW+1:2];
  assign o_inst_valid = w_nonempty && i_lock;
  assign o_inst_data  = w_nonempty ? r_data_mem[r_rd_ptr] : '0;
  assign o_inst_pc    = w_nonempty ? r_pc_mem[r_rd_ptr]   : '0;
  assign o_q_count    = r_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: an imem responder, a scoreboard of expected PCs refilled on
// every reset/redirect, and a monitor that checks each accepted head against it.
module tb_fetch_queue_unit;

  localparam int PCW   = 16;
  localparam int IRW   = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lock = 1'b0;
  logic [AW-1:0]   imem_addr;
  logic            imem_en;
  logic [IRW-1:0]  imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [PCW-1:0]  redirect_pc = '0;
  logic            inst_valid;
  logic [IRW-1:0]  inst_data;
  logic [PCW-1:0]  inst_pc;
  logic            inst_ready = 1'b0;
  logic [2:0]      q_count;

  logic [IRW-1:0]  mem [64];
  logic [PCW-1:0]  sb_q [$];
  int              checks = 0;
  int              failures = 0;
  int              pops = 0;

  fetch_queue_unit #(
    .PC_WIDTH(PCW), .IR_WIDTH(IRW), .IMEM_AW(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_lock(lock),
    .o_imem_addr(imem_addr), .o_imem_en(imem_en), .i_imem_rdata(imem_rdata),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_inst_valid(inst_valid), .o_inst_data(inst_data), .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready), .o_q_count(q_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model: data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // The expected stream is simply consecutive word addresses from the new start point.
  task automatic sb_restart(input logic [PCW-1:0] base);
    sb_q.delete();
    for (int i = 0; i < 1024; i++) sb_q.push_back(base + PCW'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [PCW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    sb_restart(target & 16'hFFFC);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_count"}, 32'(q_count), 32'd0);
    check({tag, "_en"},    32'(imem_en), 32'd0);
    check({tag, "_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_pc"},    32'(inst_pc), 32'd0);
    check({tag, "_data"},  inst_data, 32'd0);
  endtask

  always @(negedge clk) begin
    logic [PCW-1:0] exp_pc;
    if (rst_n) begin
      check("valid_rule", 32'(inst_valid), 32'((q_count != 3'd0) && lock));
      check("count_bound", 32'(q_count <= 3'(DEPTH)), 32'd1);
      if (!lock) check("no_req_when_unlocked", 32'(imem_en), 32'd0);
      if (inst_valid && inst_ready && lock && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          exp_pc = sb_q.pop_front();
          check("inst_pc", 32'(inst_pc), 32'(exp_pc));
          check("inst_data", inst_data, mem[exp_pc[7:2]]);
          pops++;
        end
      end
    end
  end

  initial begin
    bit              found;
    int              p0;
    int              n;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   addrs [3];
    logic [PCW-1:0]  rpc;

    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    #12;
    check_reset_outputs("reset");

    // Start streaming and measure the fetch-to-valid latency.
    @(posedge clk); #1;
    rst_n = 1'b1; lock = 1'b1; inst_ready = 1'b1;
    sb_restart(16'h0000);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_en) found = 1;
    end
    check("first_req_seen", 32'(found), 32'd1);
    check("first_req_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("lat_after_req_edge", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("lat_after_capture", 32'(inst_valid), 32'd1);
    check("lat_head_pc", 32'(inst_pc), 32'd0);
    repeat (20) step();
    check("stream_progress", 32'(pops >= 15), 32'd1);

    // Backpressure fills the queue and stalls fetch.
    inst_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("full_count", 32'(q_count), 32'd4);
    check("full_no_req", 32'(imem_en), 32'd0);
    step();
    inst_ready = 1'b1;
    p0 = pops;
    repeat (12) step();
    check("drain_progress", 32'(pops - p0 >= 4), 32'd1);

    // Redirect with a backlog of three and one fetch in flight.
    inst_ready = 1'b0;
    repeat (2) step();
    check("pre_redirect_count", 32'(q_count), 32'd3);
    do_redirect(16'h0023);
    check("flush_count", 32'(q_count), 32'd0);
    check("flush_valid", 32'(inst_valid), 32'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (inst_valid) found = 1;
    end
    check("post_redirect_valid", 32'(found), 32'd1);
    check("post_redirect_pc", 32'(inst_pc), 32'h0020);
    step();
    inst_ready = 1'b1;
    repeat (8) step();

    // Lock low: everything frozen.
    lock = 1'b0;
    @(negedge clk);
    a0 = imem_addr;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("locked_valid", 32'(inst_valid), 32'd0);
      check("locked_addr", 32'(imem_addr), 32'(a0));
    end
    step();
    lock = 1'b1;
    repeat (10) step();

    // Redirect near the top of the address space to exercise PC wrap.
    do_redirect(16'hFFF8);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (imem_en) begin
        addrs[n] = imem_addr;
        n++;
      end
    end
    check("wrap_req_count", 32'(n), 32'd3);
    check("wrap_addr0", 32'(addrs[0]), 32'h3E);
    check("wrap_addr1", 32'(addrs[1]), 32'h3F);
    check("wrap_addr2", 32'(addrs[2]), 32'h00);
    step();
    repeat (10) step();

    // Randomised traffic: lock, ready and redirects (some while unlocked, hence ignored).
    for (int c = 0; c < 500; c++) begin
      lock       = ($urandom_range(0, 9) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        rpc            = PCW'($urandom);
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        if (lock) sb_restart(rpc & 16'hFFFC);
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    lock = 1'b1;
    inst_ready = 1'b1;
    p0 = pops;
    repeat (20) step();
    check("random_tail_progress", 32'(pops - p0 >= 10), 32'd1);

    // Asynchronous reset with a full queue.
    inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (q_count == 3'd4) found = 1;
    end
    check("prereset_full", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_restart(16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (inst_valid) found = 1;
    end
    check("restart_valid", 32'(found), 32'd1);
    check("restart_pc", 32'(inst_pc), 32'h0000);
    step();
    inst_ready = 1'b1;
    p0 = pops;
    repeat (20) step();
    check("restart_progress", 32'(pops - p0 >= 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction fetch stage that feeds the execute datapath.
- Holds the fetch PC and drives a synchronous-read instruction memory.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them downstream with a valid/ready handshake.
- Accepts a redirect (branch, JMP or JSR target) from the datapath that flushes the buffer and any in-flight fetch.

Parameters:
- PC_WIDTH, 16, width of the byte-address PC.
- IR_WIDTH, 32, instruction width.
- IMEM_AW, 6, instruction memory word-address width (64 words).
- DEPTH, 4, FIFO entries (power of two, at least 2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset.
- lock  in  1  global enable; low freezes fetch and dequeue.
- imem_addr  out  IMEM_AW  word address; equals PC[IMEM_AW+1:2].
- imem_en  out  1  read request this cycle.
- imem_rdata  in  IR_WIDTH  read data, valid exactly 1 cycle after imem_en.
- redirect_valid  in  1  one-cycle redirect strobe.
- redirect_pc  in  PC_WIDTH  redirect byte address.
- inst_valid  out  1  FIFO head valid.
- inst_data  out  IR_WIDTH  head instruction.
- inst_pc  out  PC_WIDTH  byte PC of the head instruction.
- inst_ready  in  1  consumer accepts the head.
- q_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately forces the reset values below. Deassertion is sampled on clk.
- Reset values:
  - fetch_pc = RESET_PC.
  - imem_en = 0; imem_addr = RESET_PC[IMEM_AW+1:2].
  - inst_valid = 0; inst_data = 0; inst_pc = 0; q_count = 0.
  - In-flight flag = 0; state = BOOT.
- States:
  - BOOT → RUN on the first cycle with lock = 1. No request is issued in BOOT.
  - RUN: issue a request when lock = 1 and q_count + inflight < DEPTH; otherwise go to FULL.
  - FULL → RUN when a slot frees.
  - Any state except BOOT → FLUSH on redirect_valid && lock.
  - FLUSH → RUN after exactly 1 cycle.
- Request:
  - imem_en = 1 with imem_addr from fetch_pc.
  - On the same edge, fetch_pc ← fetch_pc + 4, modulo 2^PC_WIDTH (wraps 0xFFFC → 0x0000).
  - The request PC is latched alongside the in-flight flag.
- Response:
  - The cycle after a request, imem_rdata and its PC are enqueued.
  - Capture happens even if lock has dropped; the reserved slot guarantees no overflow.
- Fetch-to-valid latency: 2 cycles from the request edge (request edge, then capture edge; inst_valid visible after the capture edge).
- Dequeue happens when inst_valid && inst_ready && lock. Simultaneous enqueue and dequeue leave q_count unchanged.
- inst_valid = (q_count != 0) && lock. The head is stable while not dequeued.
- Redirect (redirect_valid && lock):
  - FIFO cleared (q_count ← 0).
  - The in-flight response is dropped when it returns.
  - fetch_pc ← {redirect_pc[PC_WIDTH-1:2], 2'b00}; misaligned low bits are ignored.
  - No request is issued in the redirect cycle or in FLUSH.
  - First request goes out in the cycle after FLUSH; it is the first fetch from the new PC.
  - A redirect beats any coincident enqueue or dequeue; a coincident handshake is absorbed by the flush.
- Redirect while lock = 0 is ignored.
- lock = 0:
  - No new request; fetch_pc and state are frozen.
  - No dequeue; only a pending response capture occurs.
- Back-to-back redirects: each restarts FLUSH; only the last target is fetched.
- Reset asserted mid-operation: all state returns to reset values immediately; any response arriving after reset is ignored.

Test Plan:
- Reset + lock=1, inst_ready=1, imem word k = 0x1000_0000+k → head (inst_pc, inst_data) yields (0x0000, 0x10000000), (0x0004, 0x10000001), … one per cycle after 2-cycle latency.
- inst_ready=0 for 10 cycles → q_count saturates at 4, imem_en low, FULL state. Releasing ready yields PCs 0x0000–0x000C in order with none lost or duplicated.
- Redirect to 0x0023 with 3 entries queued and one in flight → q_count=0 next cycle, in-flight data discarded, next delivered inst_pc=0x0020.
- lock low for 5 cycles mid-stream → inst_valid=0, fetch_pc frozen, no imem_en. After lock rises, the stream continues at the next PC with no gap or duplicate.
- Redirect to 0xFFF8 → PCs 0xFFF8, 0xFFFC, 0x0000 delivered. imem_addr follows PC[7:2] (0x3E, 0x3F, 0x00).
- rst_n pulsed low mid-stream with FIFO full → outputs at reset values immediately. After release, fetch restarts at RESET_PC with no stale entries.
